multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Multicycle control FSM that sequences the processor datapath through fetch, decode, execute, memory and writeback. It replaces single-cycle enabling of the register file, data memory, flags and PC with per-state strobes. It also performs ready/request handshakes with instruction and data memory. It sits between the memories and the combinational decoder: the decoder still drives the mux/ALU/shifter selects, and this block gates every state-changing write.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  contents of instruction register (valid from DECODE onward)
- cond_pass  in  1  condition field instr[31:28] satisfied by current NZCV flags
- imem_ready  in  1  instruction memory has data this cycle
- dmem_ready  in  1  data memory access completes this cycle
- imem_req  out  1  instruction fetch request
- ir_wen  out  1  load instruction register
- pc_inc_wen  out  1  PC <= PC+1
- pc_load  out  1  PC <= ALU result (branch)
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (qualifies dmem_req)
- regFile_wen  out  1  register file write
- wb_mem_sel  out  1  writeback source: 1 = memory data, 0 = ALU
- link_sel  out  1  write destination forced to R14
- flags_wen  out  1  update NZCV
- mul_step  out  1  advance external shift-add multiplier one bit
- retired  out  1  one-cycle pulse: instruction finished
- state  out  3  current state encoding (debug)

## Operation
- States (encoding): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BR=5, MUL=6, MULWB=7.
- Outputs are combinational from state, instr and the ready inputs. Every output not listed for a state is 0.
- FETCH: imem_req=1. When imem_ready=1, ir_wen=1, pc_inc_wen=1 and go to DECODE. Otherwise hold.
- DECODE:
  - If cond_pass=0: retired=1, go to FETCH.
  - Otherwise go by op=instr[27:26]:
    - 00: go to MUL if the MUL pattern matches (instr[27:22]=0, instr[7:4]=1001) and the feature is compiled in; else go to EXEC.
    - 01: go to MEM.
    - 10: go to BR.
    - 11: retired=1, go to FETCH (treated as NOP).
- EXEC:
  - regFile_wen=1 unless cmd=instr[24:21] is in 1000–1011 (TST/TEQ/CMP/CMN).
  - flags_wen=1 if instr[20]=1 or cmd is in 1000–1011.
  - retired=1, go to FETCH.
- MEM: dmem_req=1, dmem_we=~instr[20]. Hold until dmem_ready=1, then:
  - load (instr[20]=1): go to WB;
  - store: retired=1, go to FETCH.
- WB: regFile_wen=1, wb_mem_sel=1, retired=1, go to FETCH.
- BR:
  - pc_load=1.
  - If instr[24]=1 (link): regFile_wen=1 and link_sel=1, writing return PC to R14.
  - retired=1, go to FETCH.
- MUL:
  - 5-bit counter cleared on DECODE→MUL entry; mul_step=1 every MUL cycle.
  - When the counter reaches 31, go to MULWB; otherwise increment. Exactly 32 steps.
- MULWB: regFile_wen=1, flags_wen=instr[20], retired=1, go to FETCH.
- Write-enable exclusivity: in any cycle at most one of regFile_wen and (dmem_req&dmem_we) is high. pc_load and pc_inc_wen are never both high.

## Timing
- Reset (asynchronous, rst_n=0):
  - state=FETCH and counter=0 immediately.
  - All outputs 0 except imem_req=1; state output reads 0.
  - Any outstanding memory request is abandoned without waiting for ready.
- Latency with zero-wait memories (ready high in the first request cycle):
  - data-processing: 3 cycles;
  - store: 3 cycles;
  - load: 4 cycles;
  - branch/BL: 3 cycles;
  - condition-failed or op=11: 2 cycles;
  - MUL: 35 cycles.
- Each memory wait cycle adds exactly one cycle. Requests stay asserted and stable while ready=0.
- A ready input that is high while the corresponding req is low is ignored.
- retired pulses exactly once per instruction, in its final cycle.

## Configuration
- SEQ_MUL_EN defined: MUL/MULWB states, the counter and mul_step exist; MUL instructions execute as described.
- SEQ_MUL_EN undefined:
  - the MUL pattern takes the normal data path DECODE→EXEC;
  - states 6/7 are unreachable;
  - mul_step is tied to 0.

## Test plan
- Reset, then instr=0xE0811002 (ADD) with imem_ready=1 always: states 0→1→2→0; regFile_wen=1 only in EXEC; retired at cycle 3.
- instr=0xE5912000 (LDR), dmem_ready low for 2 cycles: MEM held 3 cycles with dmem_req=1, dmem_we=0; then WB with wb_mem_sel=1 and regFile_wen=1; total 6 cycles.
- instr=0xEB000004 (BL): BR cycle asserts pc_load=1, regFile_wen=1 and link_sel=1. Repeat with 0xEA000004 (B): regFile_wen=0.
- instr=0x01500001 (CMPEQ) with cond_pass=0: DECODE→FETCH; no flags_wen, no regFile_wen; retired in cycle 2.
- SEQ_MUL_EN defined, instr=0xE0020091 (MUL): 32 consecutive mul_step cycles, then MULWB regFile_wen=1; retired at cycle 35. Undefined: single EXEC cycle.
- Drive rst_n=0 during MEM with dmem_req=1: dmem_req drops in the same cycle, state=0, and no write strobe ever fires.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
//
// Multicycle control FSM for the processor datapath. It steps each instruction
// through fetch, decode, execute, memory and writeback. Every state-changing
// write (register file, data memory, flags, PC, instruction register) is
// gated by a per-state strobe. The combinational decoder still drives the
// mux/ALU/shifter selects.
//
// Optional feature macro: SEQ_MUL_EN
//   defined   : MUL/MULWB states, 5-bit step counter and mul_step are built;
//               the MUL pattern runs a 32-step shift-add multiply.
//   undefined : the MUL pattern decodes as ordinary data-processing (EXEC),
//               states 6/7 are unreachable and o_mul_step is tied to 0.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   i_instr[31:0]  in   instruction register contents (valid from DECODE on)
//   i_cond_pass    in   condition field satisfied by current NZCV
//   i_imem_ready   in   instruction memory has data this cycle
//   i_dmem_ready   in   data memory access completes this cycle
//   o_imem_req     out  instruction fetch request
//   o_ir_wen       out  load instruction register
//   o_pc_inc_wen   out  PC <= PC+1
//   o_pc_load      out  PC <= ALU result (branch)
//   o_dmem_req     out  data memory request
//   o_dmem_we      out  data memory write (qualifies o_dmem_req)
//   o_regfile_wen  out  register file write
//   o_wb_mem_sel   out  writeback source: 1 = memory data, 0 = ALU
//   o_link_sel     out  write destination forced to R14
//   o_flags_wen    out  update NZCV
//   o_mul_step     out  advance external shift-add multiplier one bit
//   o_retired      out  one-cycle pulse in the final cycle of an instruction
//   o_state[2:0]   out  current state encoding (debug)
//
// state  | meaning
// FETCH  | request instruction, wait for imem_ready
// DECODE | evaluate condition and opcode class
// EXEC   | data-processing writeback / flag update
// MEM    | load/store access, wait for dmem_ready
// WB     | write load data to register file
// BR     | branch, optional link write to R14
// MUL    | 32 multiplier steps
// MULWB  | write multiply result
// ---------------------------------------------------------------------------
module multicycle_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_instr,
    input  logic        i_cond_pass,
    input  logic        i_imem_ready,
    input  logic        i_dmem_ready,
    output logic        o_imem_req,
    output logic        o_ir_wen,
    output logic        o_pc_inc_wen,
    output logic        o_pc_load,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic        o_regfile_wen,
    output logic        o_wb_mem_sel,
    output logic        o_link_sel,
    output logic        o_flags_wen,
    output logic        o_mul_step,
    output logic        o_retired,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BR     = 3'd5,
        S_MUL    = 3'd6,
        S_MULWB  = 3'd7
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0] w_op;
    logic       w_is_load;
    logic       w_cmd_test;
    logic       w_imem_ready;

    assign w_op       = i_instr[27:26];
    assign w_is_load  = i_instr[20];
    // TST/TEQ/CMP/CMN occupy cmd 1000-1011, i.e. cmd[3:2] == 2'b10.
    assign w_cmd_test = (i_instr[24:23] == 2'b10);
    // While reset is held the FSM sits in FETCH; masking ready keeps the
    // IR/PC strobes quiet so only imem_req is visible during reset.
    assign w_imem_ready = i_imem_ready & rst_n;

`ifdef SEQ_MUL_EN
    logic [4:0] r_mul_cnt;
    logic       w_is_mul;

    assign w_is_mul = (i_instr[27:22] == 6'd0) && (i_instr[7:4] == 4'b1001);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_cnt <= 5'd0;
        end else if (r_state == S_DECODE && w_state_nxt == S_MUL) begin
            r_mul_cnt <= 5'd0;
        end else if (r_state == S_MUL) begin
            r_mul_cnt <= r_mul_cnt + 5'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        o_imem_req    = 1'b0;
        o_ir_wen      = 1'b0;
        o_pc_inc_wen  = 1'b0;
        o_pc_load     = 1'b0;
        o_dmem_req    = 1'b0;
        o_dmem_we     = 1'b0;
        o_regfile_wen = 1'b0;
        o_wb_mem_sel  = 1'b0;
        o_link_sel    = 1'b0;
        o_flags_wen   = 1'b0;
        o_mul_step    = 1'b0;
        o_retired     = 1'b0;

        case (r_state)
            S_FETCH: begin
                o_imem_req = 1'b1;
                if (w_imem_ready) begin
                    o_ir_wen     = 1'b1;
                    o_pc_inc_wen = 1'b1;
                    w_state_nxt  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!i_cond_pass) begin
                    o_retired   = 1'b1;
                    w_state_nxt = S_FETCH;
                end else begin
                    case (w_op)
`ifdef SEQ_MUL_EN
                        2'b00:   w_state_nxt = w_is_mul ? S_MUL : S_EXEC;
`else
                        2'b00:   w_state_nxt = S_EXEC;
`endif
                        2'b01:   w_state_nxt = S_MEM;
                        2'b10:   w_state_nxt = S_BR;
                        default: begin
                            o_retired   = 1'b1;
                            w_state_nxt = S_FETCH;
                        end
                    endcase
                end
            end
            S_EXEC: begin
                o_regfile_wen = ~w_cmd_test;
                o_flags_wen   = i_instr[20] | w_cmd_test;
                o_retired     = 1'b1;
                w_state_nxt   = S_FETCH;
            end
            S_MEM: begin
                o_dmem_req = 1'b1;
                o_dmem_we  = ~w_is_load;
                if (i_dmem_ready) begin
                    if (w_is_load) begin
                        w_state_nxt = S_WB;
                    end else begin
                        o_retired   = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_WB: begin
                o_regfile_wen = 1'b1;
                o_wb_mem_sel  = 1'b1;
                o_retired     = 1'b1;
                w_state_nxt   = S_FETCH;
            end
            S_BR: begin
                o_pc_load     = 1'b1;
                o_regfile_wen = i_instr[24];
                o_link_sel    = i_instr[24];
                o_retired     = 1'b1;
                w_state_nxt   = S_FETCH;
            end
`ifdef SEQ_MUL_EN
            S_MUL: begin
                o_mul_step = 1'b1;
                if (r_mul_cnt == 5'd31) begin
                    w_state_nxt = S_MULWB;
                end
            end
            S_MULWB: begin
                o_regfile_wen = 1'b1;
                o_flags_wen   = i_instr[20];
                o_retired     = 1'b1;
                w_state_nxt   = S_FETCH;
            end
`endif
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    assign o_state = r_state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Directed vectors for multicycle_sequencer. The stimulus process drives one
// clock cycle at a time and pushes the hand-derived expected state/strobe
// vector for that cycle into a queue; the monitor pops and compares on the
// falling edge. Build with +define+SEQ_MUL_EN to exercise the multiply path.
// ---------------------------------------------------------------------------
module tb_multicycle_sequencer;

    localparam logic [11:0] M_IREQ = 12'h800;
    localparam logic [11:0] M_IRW  = 12'h400;
    localparam logic [11:0] M_PCI  = 12'h200;
    localparam logic [11:0] M_PCL  = 12'h100;
    localparam logic [11:0] M_DREQ = 12'h080;
    localparam logic [11:0] M_DWE  = 12'h040;
    localparam logic [11:0] M_RFW  = 12'h020;
    localparam logic [11:0] M_WBM  = 12'h010;
    localparam logic [11:0] M_LNK  = 12'h008;
    localparam logic [11:0] M_FLG  = 12'h004;
    localparam logic [11:0] M_MUL  = 12'h002;
    localparam logic [11:0] M_RET  = 12'h001;
    localparam logic [11:0] M_NONE = 12'h000;

    typedef struct {
        logic [2:0]  st;
        logic [11:0] mask;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        cond_pass;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req, ir_wen, pc_inc_wen, pc_load, dmem_req, dmem_we;
    logic        regfile_wen, wb_mem_sel, link_sel, flags_wen, mul_step, retired;
    logic [2:0]  state;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    multicycle_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_instr       (instr),
        .i_cond_pass   (cond_pass),
        .i_imem_ready  (imem_ready),
        .i_dmem_ready  (dmem_ready),
        .o_imem_req    (imem_req),
        .o_ir_wen      (ir_wen),
        .o_pc_inc_wen  (pc_inc_wen),
        .o_pc_load     (pc_load),
        .o_dmem_req    (dmem_req),
        .o_dmem_we     (dmem_we),
        .o_regfile_wen (regfile_wen),
        .o_wb_mem_sel  (wb_mem_sel),
        .o_link_sel    (link_sel),
        .o_flags_wen   (flags_wen),
        .o_mul_step    (mul_step),
        .o_retired     (retired),
        .o_state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [11:0] act;
            e   = q.pop_front();
            act = {imem_req, ir_wen, pc_inc_wen, pc_load, dmem_req, dmem_we,
                   regfile_wen, wb_mem_sel, link_sel, flags_wen, mul_step, retired};
            n_chk++;
            if (state !== e.st || act !== e.mask) begin
                $display("FAIL %s: got state=%0d strobes=%03h, want state=%0d strobes=%03h",
                         e.name, state, act, e.st, e.mask);
            end else begin
                n_pass++;
            end
        end
    end

    // One clock cycle: apply ready inputs, queue the expected view, advance.
    task automatic cyc(input logic ir, input logic dr, input logic [2:0] st,
                       input logic [11:0] mask, input string name);
        exp_t e;
        imem_ready = ir;
        dmem_ready = dr;
        e.st   = st;
        e.mask = mask;
        e.name = name;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] ins, input logic cp);
        instr     = ins;
        cond_pass = cp;
    endtask

    initial begin
        rst_n      = 1'b0;
        instr      = 32'h0;
        cond_pass  = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset with both readies high: only imem_req visible.
        cyc(1, 1, 3'd0, M_IREQ, "reset");
        rst_n = 1'b1;

        // ADD: FETCH -> DECODE -> EXEC
        start(32'hE0811002, 1);
        cyc(1, 0, 3'd0, M_IREQ | M_IRW | M_PCI, "add_fetch");
        cyc(1, 0, 3'd1, M_NONE, "add_decode");
        cyc(1, 0, 3'd2, M_RFW | M_RET, "add_exec");

        // LDR, dmem_ready high early (ignored), then 2 wait cycles.
        start(32'hE5912000, 1);
        cyc(1, 1, 3'd0, M_IREQ | M_IRW | M_PCI, "ldr_fetch");
        cyc(0, 1, 3'd1, M_NONE, "ldr_decode");
        cyc(0, 0, 3'd3, M_DREQ, "ldr_mem_wait1");
        cyc(0, 0, 3'd3, M_DREQ, "ldr_mem_wait2");
        cyc(0, 1, 3'd3, M_DREQ, "ldr_mem_done");
        cyc(0, 0, 3'd4, M_RFW | M_WBM | M_RET, "ldr_wb");

        // STR with one instruction-memory wait cycle, zero-wait data.
        start(32'hE5812000, 1);
        cyc(0, 0, 3'd0, M_IREQ, "str_fetch_wait");
        cyc(1, 0, 3'd0, M_IREQ | M_IRW | M_PCI, "str_fetch");
        cyc(0, 0, 3'd1, M_NONE, "str_decode");
        cyc(0, 1, 3'd3, M_DREQ | M_DWE | M_RET, "str_mem");

        // BL then B.
        start(32'hEB000004, 1);
        cyc(1, 0, 3'd0, M_IREQ | M_IRW | M_PCI, "bl_fetch");
        cyc(0, 0, 3'd1, M_NONE, "bl_decode");
        cyc(0, 0, 3'd5, M_PCL | M_RFW | M_LNK | M_RET, "bl_br");
        start(32'hEA000004, 1);
        cyc(1, 0, 3'd0, M_IREQ | M_IRW | M_PCI, "b_fetch");
        cyc(0, 0, 3'd1, M_NONE, "b_decode");
        cyc(0, 0, 3'd5, M_PCL | M_RET, "b_br");

        // CMPEQ with condition failed: retires in DECODE.
        start(32'h01500001, 0);
        cyc(1, 0, 3'd0, M_IREQ | M_IRW | M_PCI, "cmpeq_nc_fetch");
        cyc(0, 0, 3'd1, M_RET, "cmpeq_nc_decode");
        // Same CMP with condition passing: flags only, no register write.
        start(32'h01500001, 1);
        cyc(1, 0, 3'd0, M_IREQ | M_IRW | M_PCI, "cmp_fetch");
        cyc(0, 0, 3'd1, M_NONE, "cmp_decode");
        cyc(0, 0, 3'd2, M_FLG | M_RET, "cmp_exec");

        // op=11 is a NOP that retires in DECODE.
        start(32'hEF000000, 1);
        cyc(1, 0, 3'd0, M_IREQ | M_IRW | M_PCI, "nop_fetch");
        cyc(0, 0, 3'd1, M_RET, "nop_decode");

        // MUL
        start(32'hE0020091, 1);
        cyc(1, 0, 3'd0, M_IREQ | M_IRW | M_PCI, "mul_fetch");
        cyc(0, 0, 3'd1, M_NONE, "mul_decode");
`ifdef SEQ_MUL_EN
        for (int i = 0; i < 32; i++) begin
            cyc(0, 0, 3'd6, M_MUL, $sformatf("mul_step%0d", i));
        end
        cyc(0, 0, 3'd7, M_RFW | M_RET, "mul_wb");
`else
        cyc(0, 0, 3'd2, M_RFW | M_RET, "mul_as_exec");
`endif

        // Reset asserted mid-MEM of a store: request abandoned at once.
        start(32'hE5812000, 1);
        cyc(1, 0, 3'd0, M_IREQ | M_IRW | M_PCI, "rst_fetch");
        cyc(0, 0, 3'd1, M_NONE, "rst_decode");
        cyc(0, 0, 3'd3, M_DREQ | M_DWE, "rst_mem_wait");
        rst_n = 1'b0;
        cyc(1, 1, 3'd0, M_IREQ, "rst_in_mem");
        cyc(1, 1, 3'd0, M_IREQ, "rst_held");
        rst_n = 1'b1;
        // Recovery: a fresh ADD runs normally.
        start(32'hE0811002, 1);
        cyc(1, 0, 3'd0, M_IREQ | M_IRW | M_PCI, "post_rst_fetch");
        cyc(0, 0, 3'd1, M_NONE, "post_rst_decode");
        cyc(0, 0, 3'd2, M_RFW | M_RET, "post_rst_exec");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: got %0d entries pending, want 0", q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
